mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Multicycle main control unit for the MIPS datapath. It sits directly upstream of the ALU-function decoder and drives its 2-bit aluop. It sequences fetch, decode, execute, memory and writeback from the IR opcode, and issues every datapath enable and mux select. Memory accesses use a ready handshake with a bounded wait.

Parameters:
WAIT_MAX, 0, max cycles to wait for mem_ready per access; 0 = unbounded (no timeout)
CNT_W, 8, width of wait counter; WAIT_MAX must be < 2^CNT_W

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
iord  out  1  memory address mux: 0=PC, 1=ALUOut
memread  out  1  memory read request
memwrite  out  1  memory write request
irwrite  out  1  IR load enable
regdst  out  1  0=rt, 1=rd
memtoreg  out  1  0=ALUOut, 1=MDR
regwrite  out  1  register file write enable
alusrca  out  1  0=PC, 1=A
alusrcb  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
aluop  out  2  00 add, 01 sub, 10 use funct, 11 add (immediate)
pcsource  out  2  00=ALU result, 01=ALUOut, 10=jump target
pc_en  out  1  PC load enable (pcwrite or qualified branch)
illegal_op  out  1  one-cycle registered pulse on unknown opcode
mem_timeout  out  1  one-cycle registered pulse on wait expiry
state  out  4  current state, for debug

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000; bne=000101 only with the optional feature.
- State register resets to IDLE(0). While reset_n=0 or in IDLE: every output is 0 (aluop=00, state=0).
- Outputs are decoded from state (Moore). Exceptions: irwrite, and pc_en in FETCH and BRANCH, are qualified combinationally by mem_ready or zero. Any signal not listed for a state is 0.
- IDLE(0): all 0 -> FETCH.
- FETCH(1): memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00; irwrite=pc_en=mem_ready. Stay until mem_ready=1, then -> DECODE.
- DECODE(2): alusrca=0, alusrcb=11, aluop=00. Transitions by opcode:
  - lw/sw -> MEMADR
  - R -> EXEC
  - beq -> BRANCH
  - j -> JUMP
  - addi -> ADDIEX
  - other -> FETCH, and illegal_op pulses the following cycle.
- MEMADR(3): alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD(4): iord=1, memread=1. Wait for mem_ready, then -> MEMWB.
- MEMWB(5): regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR(6): iord=1, memwrite=1. Wait for mem_ready, then -> FETCH.
- EXEC(7): alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB(8): regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH(9): alusrca=1, alusrcb=00, aluop=01, pcsource=01, pc_en=zero -> FETCH.
- JUMP(10): pcsource=10, pc_en=1 -> FETCH.
- ADDIEX(11): alusrca=1, alusrcb=10, aluop=11 -> ADDIWB.
- ADDIWB(12): regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- Encodings 13-15 -> IDLE.
- Cycle counts from FETCH accept to next FETCH entry:
  - R: 4 cycles
  - addi: 4 cycles
  - lw: 5 cycles + wait cycles
  - sw: 4 cycles + wait cycles
  - beq: 3 cycles
  - j: 3 cycles
- Wait counter:
  - Clears on entry to FETCH, MEMRD and MEMWR; increments each cycle mem_ready=0 in those states.
  - If WAIT_MAX>0 and the counter reaches WAIT_MAX-1 with mem_ready=0, the next state is FETCH (re-entry restarts the counter). No irwrite, pc_en, regwrite or memwrite is issued. mem_timeout pulses next cycle.
  - mem_ready=1 on the same cycle as expiry wins; the access completes normally.
- Asynchronous reset mid-instruction forces IDLE immediately, drops all outputs to 0 and clears both pulse flags and the counter.

Optional Feature:
CTRL_BNE_EN
- Defined: opcode 000101 in DECODE -> BRANCH. BRANCH sets pc_en = zero XOR is_bne, with is_bne decoded from opcode.
- Undefined: 000101 is illegal (FETCH + illegal_op pulse); BRANCH pc_en = zero.

Test Plan:
- Reset: reset_n=0 mid-MEMRD -> state=0 and all outputs 0 that cycle; release -> IDLE, FETCH next cycle with memread=1, aluop=00.
- R-type, mem_ready=1 always: opcode=000000 -> states 1,2,7,8,1; aluop=10 in EXEC; regwrite=1 and regdst=1 in ALUWB.
- lw with 3 wait cycles in MEMRD: opcode=100011, mem_ready low 3 cycles -> memread and iord held 4 cycles, then MEMWB with memtoreg=1, regwrite=1.
- beq: zero=1 -> pc_en=1, pcsource=01, aluop=01 in BRANCH. zero=0 -> pc_en=0. With CTRL_BNE_EN, opcode=000101 and zero=0 -> pc_en=1.
- Illegal: opcode=111111 -> DECODE -> FETCH, illegal_op=1 for exactly one cycle.
- Timeout with WAIT_MAX=4: sw with mem_ready stuck 0 -> 4 cycles in MEMWR, then FETCH, mem_timeout single pulse, no regwrite or pc_en asserted.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath enables, mux selects and aluop. Optional `CTRL_BNE_EN adds bne support.
module mc_control_fsm #(
    parameter int WAIT_MAX = 0,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    localparam bit             TIMEOUT_EN = (WAIT_MAX > 0);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_MAX > 0) ? (WAIT_MAX - 1) : 0);

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             illegal_nxt;
    logic             is_bne;
    logic             waiting;
    logic             expire;
    logic             entering_wait;

`ifdef CTRL_BNE_EN
    assign is_bne = (opcode == OP_BNE);
`else
    assign is_bne = 1'b0;
`endif

    // Memory-handshake states share one wait counter; expiry needs mem_ready low.
    assign waiting = (cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR);
    assign expire  = TIMEOUT_EN && waiting && !mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state   <= S_IDLE;
            wait_cnt    <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            wait_cnt    <= wait_cnt_nxt;
            illegal_op  <= illegal_nxt;
            mem_timeout <= expire;
        end
    end

    always_comb begin
        nxt_state   = cur_state;
        illegal_nxt = 1'b0;
        case (cur_state)
            S_IDLE:   nxt_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready)   nxt_state = S_DECODE;
                else if (expire) nxt_state = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_R:         nxt_state = S_EXEC;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_J:         nxt_state = S_JUMP;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    default: begin
                        if (is_bne) begin
                            nxt_state = S_BRANCH;
                        end else begin
                            nxt_state   = S_FETCH;
                            illegal_nxt = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADR: nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)   nxt_state = S_MEMWB;
                else if (expire) nxt_state = S_FETCH;
            end
            S_MEMWB:  nxt_state = S_FETCH;
            S_MEMWR: begin
                if (mem_ready || expire) nxt_state = S_FETCH;
            end
            S_EXEC:   nxt_state = S_ALUWB;
            S_ALUWB:  nxt_state = S_FETCH;
            S_BRANCH: nxt_state = S_FETCH;
            S_JUMP:   nxt_state = S_FETCH;
            S_ADDIEX: nxt_state = S_ADDIWB;
            S_ADDIWB: nxt_state = S_FETCH;
            default:  nxt_state = S_IDLE;
        endcase
    end

    // A timeout re-entry into FETCH counts as a fresh entry and restarts the count.
    always_comb begin
        entering_wait = ((nxt_state == S_FETCH) || (nxt_state == S_MEMRD) || (nxt_state == S_MEMWR))
                        && ((nxt_state != cur_state) || expire);
        wait_cnt_nxt  = wait_cnt;
        if (entering_wait)
            wait_cnt_nxt = '0;
        else if (waiting && !mem_ready)
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end

    always_comb begin
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsource = 2'b00;
        pc_en    = 1'b0;
        case (cur_state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pc_en   = mem_ready;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsource = 2'b01;
                pc_en    = zero ^ is_bne;
            end
            S_JUMP: begin
                pcsource = 2'b10;
                pc_en    = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
            end
            S_ADDIWB: regwrite = 1'b1;
            default: ;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: an instruction-level model expands each
// instruction into expected per-cycle control words; a monitor compares every cycle.
module tb_mc_control_fsm;

    localparam int WAIT_MAX = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsource;
    logic       pc_en, illegal_op, mem_timeout;
    logic [3:0] state;

    mc_control_fsm #(.WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .pc_en(pc_en),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] ctl;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic pend_ill = 1'b0;
    logic pend_to  = 1'b0;

    logic [16:0] ctl_now;
    assign ctl_now = {iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                      alusrcb, aluop, pcsource, pc_en, illegal_op, mem_timeout};

    function automatic logic [16:0] mk(input logic io, mr, mw, irw, rd, m2r, rw, asa,
                                       input logic [1:0] asb, aop, pcs, input logic pce);
        return {io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pce, 2'b00};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        logic ok;
        ok = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
             (op == OP_J) || (op == OP_ADDI);
`ifdef CTRL_BNE_EN
        ok = ok || (op == OP_BNE);
`endif
        return ok;
    endfunction

    // Monitor: one expected record per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            total++;
            if (state !== e.st) begin
                bad++;
                $display("FAIL state cyc=%0d got=%0d want=%0d", cyc, state, e.st);
            end
            total++;
            if (ctl_now !== e.ctl) begin
                bad++;
                $display("FAIL ctl cyc=%0d state=%0d got=%05h want=%05h", cyc, state, ctl_now, e.ctl);
            end
        end
    end

    task automatic step(input logic [5:0] op, input logic z, input logic rdy, input logic rstn,
                        input logic [3:0] st, input logic [16:0] ctl);
        exp_t e;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        reset_n   = rstn;
        if (!rstn) begin
            pend_ill = 1'b0;
            pend_to  = 1'b0;
        end
        e.st  = st;
        e.ctl = ctl | {15'd0, pend_ill, pend_to};
        pend_ill = 1'b0;
        pend_to  = 1'b0;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // n cycles of mem_ready low in a handshake state, or until the wait budget runs out.
    task automatic low_wait(input logic [3:0] st, input logic [16:0] ctl, input logic [5:0] op,
                            input int n, output bit timed_out);
        timed_out = 1'b0;
        for (int i = 0; i < n; i++) begin
            step(op, rbit(), 1'b0, 1'b1, st, ctl);
            if (i == WAIT_MAX - 1) begin
                timed_out = 1'b1;
                pend_to   = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_fetch(input int nf);
        bit to;
        int n;
        n = (nf < 0) ? int'($urandom_range(0, WAIT_MAX)) : nf;
        forever begin
            low_wait(4'd1, mk(0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), 6'($urandom), n, to);
            if (!to) break;
            n = int'($urandom_range(0, 2));
        end
        step(6'($urandom), rbit(), 1'b1, 1'b1, 4'd1, mk(0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,1));
    endtask

    task automatic run_instr(input logic [5:0] op, input logic zb, input int nf, input int nm);
        bit   to;
        logic bne;
        do_fetch(nf);
        step(op, rbit(), rbit(), 1'b1, 4'd2, mk(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0));
        if (!is_legal(op)) begin
            pend_ill = 1'b1;
            return;
        end
        bne = (op == OP_BNE);
        if (op == OP_R) begin
            step(op, rbit(), rbit(), 1'b1, 4'd7, mk(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0));
            step(op, rbit(), rbit(), 1'b1, 4'd8, mk(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0));
        end else if (op == OP_ADDI) begin
            step(op, rbit(), rbit(), 1'b1, 4'd11, mk(0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0));
            step(op, rbit(), rbit(), 1'b1, 4'd12, mk(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0));
        end else if (op == OP_BEQ || bne) begin
            step(op, zb, rbit(), 1'b1, 4'd9, mk(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,zb ^ bne));
        end else if (op == OP_J) begin
            step(op, rbit(), rbit(), 1'b1, 4'd10, mk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1));
        end else if (op == OP_LW) begin
            step(op, rbit(), rbit(), 1'b1, 4'd3, mk(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
            low_wait(4'd4, mk(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), op, nm, to);
            if (!to) begin
                step(op, rbit(), 1'b1, 1'b1, 4'd4, mk(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0));
                step(op, rbit(), rbit(), 1'b1, 4'd5, mk(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0));
            end
        end else begin
            step(op, rbit(), rbit(), 1'b1, 4'd3, mk(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
            low_wait(4'd6, mk(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), op, nm, to);
            if (!to)
                step(op, rbit(), 1'b1, 1'b1, 4'd6, mk(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [0:7];
        int k;
        tbl = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_BNE, 6'b111111};
        k = int'($urandom_range(0, 8));
        if (k == 8) return 6'($urandom);
        return tbl[k];
    endfunction

    initial begin
        bit to;
        reset_n   = 1'b0;
        opcode    = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(6'($urandom), rbit(), rbit(), 1'b0, 4'd0, 17'd0);
        step(6'($urandom), rbit(), rbit(), 1'b0, 4'd0, 17'd0);
        step(6'($urandom), rbit(), rbit(), 1'b1, 4'd0, 17'd0);

        run_instr(OP_R,    1'b0, 0, 0);
        run_instr(OP_LW,   1'b0, 0, 3);
        run_instr(OP_BEQ,  1'b1, 0, 0);
        run_instr(OP_BEQ,  1'b0, 1, 0);
        run_instr(OP_BNE,  1'b0, 0, 0);
        run_instr(6'b111111, 1'b0, 0, 0);
        run_instr(OP_SW,   1'b0, 0, 4);
        run_instr(OP_J,    1'b0, 2, 0);
        run_instr(OP_ADDI, 1'b0, 0, 0);
        run_instr(OP_LW,   1'b0, 0, 4);

        // Asynchronous reset in the middle of a stalled load.
        do_fetch(0);
        step(OP_LW, rbit(), rbit(), 1'b1, 4'd2, mk(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0));
        step(OP_LW, rbit(), rbit(), 1'b1, 4'd3, mk(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
        low_wait(4'd4, mk(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), OP_LW, 2, to);
        step(OP_LW, rbit(), 1'b0, 1'b0, 4'd0, 17'd0);
        step(OP_LW, rbit(), 1'b1, 1'b0, 4'd0, 17'd0);
        step(OP_LW, rbit(), 1'b1, 1'b1, 4'd0, 17'd0);

        for (int i = 0; i < 300; i++)
            run_instr(pick_op(), rbit(), -1, int'($urandom_range(0, 5)));

        // Trailing fetch cycle catches any pulse owed by the last instruction.
        step(6'($urandom), rbit(), 1'b0, 1'b1, 4'd1, mk(0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0));

        for (int i = 0; i < 4 && expq.size() > 0; i++)
            @(negedge clk);
        #1;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t limit reached", $time);
        $fatal(1, "watchdog");
    end

endmodule
